// File: rtl/fp_mul_seq_ctrl.sv
// fp_mul_seq_ctrl: sequencing FSM for the iterative single-precision multiplier datapath.
// Optional build macro MUL_EARLY_TERM_EN adds mul_rem_zero so MULT can stop once the
// remaining multiplier bits are all zero.
module fp_mul_seq_ctrl #(
  parameter int MANT_W = 24,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_en,
  output logic             unpack_en,
  input  logic             special_i,
  output logic             bypass_sel,
  output logic             mul_step_en,
  output logic [CNT_W-1:0] mul_cnt,
  output logic             norm_en,
  output logic             round_en,
  input  logic             inexact_i,
  input  logic             overflow_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_inexact,
  output logic             out_overflow,
  output logic             sticky_inexact,
  output logic             sticky_overflow,
  input  logic             flag_clr,
`ifdef MUL_EARLY_TERM_EN
  input  logic             mul_rem_zero,
`endif
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, HOLD} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic bypass_q, bypass_d, oi_q, oi_d, oo_q, oo_d, si_q, si_d, so_q, so_d;
  logic rem_zero, last_step;
`ifdef MUL_EARLY_TERM_EN
  assign rem_zero = mul_rem_zero;
`else
  assign rem_zero = 1'b0;
`endif
  assign last_step       = mul_cnt_q == CNT_W'(MANT_W - 1);
  assign in_ready        = state_q == IDLE;
  assign busy            = state_q != IDLE;
  assign load_en         = in_valid & in_ready;
  assign unpack_en       = state_q == UNPACK;
  assign mul_step_en     = state_q == MULT && !rem_zero;
  assign norm_en         = state_q == NORM;
  assign round_en        = state_q == ROUND;
  assign out_valid       = state_q == HOLD;
  assign mul_cnt         = mul_cnt_q;
  assign bypass_sel      = bypass_q;
  assign out_inexact     = oi_q;
  assign out_overflow    = oo_q;
  assign sticky_inexact  = si_q;
  assign sticky_overflow = so_q;
  // Next-state and flag update; a ROUND-cycle set overrides a simultaneous sticky clear.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    bypass_d  = bypass_q;
    oi_d      = oi_q;
    oo_d      = oo_q;
    si_d      = flag_clr ? 1'b0 : si_q;
    so_d      = flag_clr ? 1'b0 : so_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = UNPACK;
        bypass_d = 1'b0;
      end
      UNPACK: if (special_i) begin
        state_d  = HOLD;
        bypass_d = 1'b1;
        oi_d     = 1'b0;
        oo_d     = 1'b0;
      end else begin
        state_d   = MULT;
        mul_cnt_d = '0;
      end
      MULT: if (rem_zero) begin
        state_d = NORM;
      end else if (last_step) begin
        state_d   = NORM;
        mul_cnt_d = '0;
      end else begin
        mul_cnt_d = mul_cnt_q + CNT_W'(1);
      end
      NORM: begin
        state_d   = ROUND;
        mul_cnt_d = '0;
      end
      ROUND: begin
        state_d = HOLD;
        oi_d    = inexact_i;
        oo_d    = overflow_i;
        si_d    = si_d | inexact_i;
        so_d    = so_d | overflow_i;
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // State and flag registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mul_cnt_q <= '0;
      bypass_q  <= 1'b0;
      oi_q      <= 1'b0;
      oo_q      <= 1'b0;
      si_q      <= 1'b0;
      so_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      bypass_q  <= bypass_d;
      oi_q      <= oi_d;
      oo_q      <= oo_d;
      si_q      <= si_d;
      so_q      <= so_d;
    end
  end
endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// tb_fp_mul_seq_ctrl: vector table, hand sequences and randomized ops against a transaction model.
module tb_fp_mul_seq_ctrl;
  localparam int MANT_W = 24;
  localparam int CNT_W  = 5;
  localparam int LAT_N  = MANT_W + 4;
  logic clk = 1'b0;
  logic rst, in_valid, special_i, inexact_i, overflow_i, out_ready, flag_clr, mul_rem_zero;
  logic in_ready, load_en, unpack_en, bypass_sel, mul_step_en, norm_en, round_en;
  logic out_valid, out_inexact, out_overflow, sticky_inexact, sticky_overflow, busy;
  logic [CNT_W-1:0] mul_cnt;
  int n_cmp = 0;
  int n_fail = 0;
  bit m_si, m_so;

  fp_mul_seq_ctrl #(.MANT_W(MANT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .load_en(load_en),
    .unpack_en(unpack_en), .special_i(special_i), .bypass_sel(bypass_sel),
    .mul_step_en(mul_step_en), .mul_cnt(mul_cnt), .norm_en(norm_en), .round_en(round_en),
    .inexact_i(inexact_i), .overflow_i(overflow_i), .out_valid(out_valid),
    .out_ready(out_ready), .out_inexact(out_inexact), .out_overflow(out_overflow),
    .sticky_inexact(sticky_inexact), .sticky_overflow(sticky_overflow),
    .flag_clr(flag_clr),
`ifdef MUL_EARLY_TERM_EN
    .mul_rem_zero(mul_rem_zero),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sp, ix, ov; int stall; bit clr;
    int lat, steps; bit byp, oi, oo, si, so;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " in_ready"}, in_ready, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " mul_cnt"}, mul_cnt, 0);
    chk({tag, " strobes"}, {load_en, unpack_en, mul_step_en, norm_en, round_en}, 0);
  endtask

  // One operation from an IDLE negedge through the output handshake.
  task automatic do_op(input string tag, input bit sp, ix, ov, input int stall, input bit clr_rnd,
                       input bit keep_valid, input int e_lat, e_steps,
                       input bit e_byp, e_oi, e_oo, e_si, e_so);
    int c, steps, viol, hv;
    bit seen;
    chk({tag, " ready"}, in_ready, 1);
    in_valid = 1; special_i = sp; inexact_i = ix; overflow_i = ov; out_ready = 0;
    #1 chk({tag, " load_en"}, load_en, 1);
    c = 0; steps = 0; viol = 0; seen = 0;
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (out_valid) seen = 1;
      else begin
        if (mul_step_en) begin
          if (mul_cnt != CNT_W'(steps)) viol++;
          steps++;
        end
        if (load_en || in_ready || !busy) viol++;
        if ($countones({load_en, unpack_en, mul_step_en, norm_en, round_en}) > 1) viol++;
      end
      in_valid = keep_valid;
      flag_clr = clr_rnd && c == MANT_W + 3;
    end
    flag_clr = 0;
    chk({tag, " latency"}, c, e_lat);
    chk({tag, " steps"}, steps, e_steps);
    chk({tag, " protocol"}, viol, 0);
    chk({tag, " bypass"}, bypass_sel, e_byp);
    chk({tag, " out_inexact"}, out_inexact, e_oi);
    chk({tag, " out_overflow"}, out_overflow, e_oo);
    chk({tag, " sticky_inexact"}, sticky_inexact, e_si);
    chk({tag, " sticky_overflow"}, sticky_overflow, e_so);
    hv = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (out_valid !== 1 || bypass_sel !== e_byp || out_inexact !== e_oi ||
          out_overflow !== e_oo || in_ready !== 0) hv++;
    end
    chk({tag, " hold"}, hv, 0);
    out_ready = 1;
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #1 chk({tag, " back idle"}, {in_ready, busy, out_valid}, 3'b100);
  endtask

  initial begin
    int c, loads, last, bad;
    bit found;
    rst = 1; in_valid = 0; special_i = 0; inexact_i = 0; overflow_i = 0;
    out_ready = 0; flag_clr = 0; mul_rem_zero = 0;
    tbl[0] = '{0, 0, 0, 0, 0, LAT_N, MANT_W, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 0, 0, 2,     0,      1, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 1, 5, 0, LAT_N, MANT_W, 0, 1, 1, 1, 1};
    tbl[3] = '{1, 0, 0, 0, 0, 2,     0,      1, 0, 0, 1, 1};
    tbl[4] = '{0, 1, 0, 0, 1, LAT_N, MANT_W, 0, 1, 0, 1, 0};
    tbl[5] = '{0, 0, 1, 2, 0, LAT_N, MANT_W, 0, 0, 1, 1, 1};
    @(negedge clk); @(negedge clk);
    chk_idle("reset");
    chk("reset sticky", {sticky_inexact, sticky_overflow, bypass_sel, out_inexact, out_overflow}, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      do_op($sformatf("vec%0d", i), tbl[i].sp, tbl[i].ix, tbl[i].ov, tbl[i].stall, tbl[i].clr,
            0, tbl[i].lat, tbl[i].steps, tbl[i].byp, tbl[i].oi, tbl[i].oo, tbl[i].si, tbl[i].so);
    flag_clr = 1;
    @(negedge clk);
    flag_clr = 0;
    chk("flag_clr alone", {sticky_inexact, sticky_overflow}, 0);
    do_op("preset", 0, 1, 1, 0, 0, 0, LAT_N, MANT_W, 0, 1, 1, 1, 1);
    // Reset in the middle of MULT.
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    c = 0; found = 0;
    while (!found && c < 60) begin
      @(negedge clk);
      c++;
      found = mul_step_en && mul_cnt == 10;
    end
    chk("reach mul_cnt 10", found, 1);
    rst = 1;
    #1 chk_idle("midrst");
    chk("midrst flags", {sticky_inexact, sticky_overflow, bypass_sel, out_inexact, out_overflow}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post-rst no valid", out_valid, 0);
    do_op("after rst", 0, 0, 0, 0, 0, 0, LAT_N, MANT_W, 0, 0, 0, 0, 0);
    // Continuous in_valid with out_ready high: one accept per MANT_W+5 cycles.
    in_valid = 1; out_ready = 1; special_i = 0; inexact_i = 0; overflow_i = 0;
    loads = 0; last = -1; bad = 0;
    for (int i = 0; i <= 3 * (MANT_W + 5); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (load_en) begin
        if (last >= 0 && i - last != MANT_W + 5) bad++;
        if (!in_ready) bad++;
        last = i; loads++;
      end
    end
    chk("throughput loads", loads, 4);
    chk("throughput spacing", bad, 0);
    in_valid = 0; out_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
`ifdef MUL_EARLY_TERM_EN
    begin
      int steps, ncyc, ncnt, vc;
      in_valid = 1;
      #1 chk("et load", load_en, 1);
      c = 0; steps = 0; ncyc = -1; ncnt = -1; vc = -1;
      while (vc < 0 && c < 60) begin
        @(negedge clk);
        c++;
        in_valid = 0;
        mul_rem_zero = c == 5;
        #1;
        if (mul_step_en) steps++;
        if (norm_en) begin ncyc = c; ncnt = int'(mul_cnt); end
        if (out_valid) vc = c;
      end
      mul_rem_zero = 0;
      chk("et steps", steps, 3);
      chk("et norm cycle", ncyc, 6);
      chk("et norm mul_cnt", ncnt, 3);
      chk("et out_valid cycle", vc, 8);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("et idle cnt", mul_cnt, 0);
    end
`endif
    // Randomized operations against the transaction model.
    m_si = 0; m_so = 0;
    for (int i = 0; i < 25; i++) begin
      bit sp, ix, ov, clr, kv;
      int stall;
      sp = $urandom_range(0, 3) == 0;
      ix = 1'($urandom); ov = 1'($urandom); clr = 1'($urandom); kv = 1'($urandom);
      stall = $urandom_range(0, 3);
      if (!sp) begin
        m_si = clr ? ix : (m_si | ix);
        m_so = clr ? ov : (m_so | ov);
      end
      do_op($sformatf("rnd%0d", i), sp, ix, ov, stall, clr, kv, sp ? 2 : LAT_N, sp ? 0 : MANT_W,
            sp, sp ? 1'b0 : ix, sp ? 1'b0 : ov, m_si, m_so);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mul_seq_ctrl.md
Name: fp_mul_seq_ctrl

Overview:
- Control FSM for the iterative single-precision multiplier datapath: unpack, 24-step shift-add mantissa multiply, normalize, round/pack.
- Accepts one operand pair per valid/ready handshake and emits one-cycle stage-enable strobes to the datapath.
- Presents the result with a valid/ready handshake and keeps per-operation and sticky exception flags.
- Sits between the issuing unit and the multiplier datapath, which includes the rounding stage.

Parameters:
- MANT_W, 24, number of mantissa multiply iterations (hidden bit included).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= MANT_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- load_en  out  1  datapath captures operands; equals in_valid & in_ready.
- unpack_en  out  1  unpack/special-detect strobe.
- special_i  in  1  zero/inf/NaN detected by the datapath; sampled in UNPACK.
- bypass_sel  out  1  result comes from the special-case path; valid while out_valid.
- mul_step_en  out  1  one shift-add iteration.
- mul_cnt  out  CNT_W  current iteration index.
- norm_en  out  1  normalize strobe.
- round_en  out  1  round/pack strobe.
- inexact_i  in  1  rounding stage inexact; sampled in ROUND.
- overflow_i  in  1  rounding stage exponent overflow; sampled in ROUND.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_inexact  out  1  per-operation inexact flag; valid with out_valid.
- out_overflow  out  1  per-operation overflow flag; valid with out_valid.
- sticky_inexact  out  1  accumulated inexact.
- sticky_overflow  out  1  accumulated overflow.
- flag_clr  in  1  clears both sticky flags.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - State goes to IDLE. mul_cnt=0, bypass_sel=0, out_valid=0.
  - out_inexact, out_overflow and both sticky flags are 0.
  - All strobes are 0. in_ready=1, busy=0.
  - Reset mid-operation abandons the operation; no out_valid is produced for it.
- States: IDLE, UNPACK, MULT, NORM, ROUND, HOLD (one-hot or binary, implementer's choice).
- IDLE:
  - in_ready=1.
  - On in_valid: load_en=1 for that cycle; next UNPACK; bypass_sel cleared.
- UNPACK:
  - unpack_en=1.
  - If special_i=1: bypass_sel<=1, out_inexact<=0, out_overflow<=0, next HOLD.
  - Otherwise mul_cnt<=0, next MULT.
- MULT:
  - mul_step_en=1 every cycle; mul_cnt increments each cycle.
  - When mul_cnt==MANT_W-1, next NORM and mul_cnt<=0.
  - The state lasts exactly MANT_W cycles.
- NORM: norm_en=1 for one cycle; next ROUND.
- ROUND:
  - round_en=1.
  - out_inexact<=inexact_i, out_overflow<=overflow_i.
  - Sticky flags OR in the same values.
  - Next HOLD.
- HOLD:
  - out_valid=1; outputs are held stable until out_ready.
  - On out_ready: next IDLE.
  - No new operand is accepted in the handshake cycle; in_ready first rises in IDLE.
- Latency (handshake cycle = 0):
  - Normal operation: out_valid first at cycle MANT_W+4 (28 for the default).
  - Special case: out_valid first at cycle 2.
  - Throughput: one operation per MANT_W+5 cycles with out_ready tied high.
- Strobes:
  - Combinational decode of state; at most one of load_en, unpack_en, mul_step_en, norm_en, round_en is high in any cycle.
- Sticky flags:
  - Cleared by flag_clr.
  - If flag_clr coincides with a ROUND-cycle set, the set wins: new value = the incoming flag.
- in_valid outside IDLE is ignored and operands are not captured.
- busy = (state != IDLE).

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- With the macro defined:
  - Adds input mul_rem_zero (remaining multiplier bits all zero).
  - In MULT, if mul_rem_zero=1: mul_step_en=0 that cycle and next NORM.
  - mul_cnt holds the number of completed steps through NORM, so the datapath can apply the remaining alignment shift.
  - mul_cnt is cleared on leaving NORM.
- Without the macro: no mul_rem_zero port; MULT always runs MANT_W cycles.

Test Plan:
- Reset, then in_valid with 1.5×2.0 operands (special_i=0, inexact_i=0, overflow_i=0), out_ready=1 -> load_en at cycle 0; 24 mul_step_en pulses with mul_cnt 0..23; out_valid at cycle 28; out_inexact=0; in_ready high again at cycle 29.
- special_i=1 in UNPACK (0×inf) -> no mul_step_en; bypass_sel=1 and out_valid at cycle 2; sticky flags unchanged.
- inexact_i=1 and overflow_i=1 in ROUND, out_ready low for 5 cycles -> out_valid and flags held 5 cycles; sticky flags set.
  - flag_clr asserted alone afterwards -> sticky flags return to 0.
  - flag_clr asserted in a ROUND cycle with inexact_i=1 -> sticky_inexact stays 1.
- Assert rst during MULT at mul_cnt=10 -> all outputs at reset values immediately; next operation completes with normal 28-cycle latency.
- in_valid held high continuously with out_ready=1 -> accepts exactly every 29 cycles; no load_en outside IDLE.
- With MUL_EARLY_TERM_EN: mul_rem_zero=1 at mul_cnt=3 -> 3 mul_step_en pulses; norm_en next cycle with mul_cnt=3; out_valid at cycle 8.
